// File: rtl/chunk_shift_accumulator.sv
// Serial shift-and-add multiplier over the chunked value from the division stage.
// Optional build macro CHUNK_CHECK_EN: flags chunk weights that disagree with the running bit position.
module chunk_shift_accumulator #(
  parameter int OP_W   = 8,
  parameter int CHUNKS = 6,
  parameter int RES_W  = 12 + OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       n,
  input  logic [5:0]       divisionBit,
  input  logic [17:0]      divisionOut,
  input  logic [23:0]      divisionWeight,
  input  logic [OP_W-1:0]  operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  logic [3:0]       nReg;
  logic [5:0]       bitReg;
  logic [17:0]      outReg;
  logic [23:0]      weightReg;
  logic [OP_W-1:0]  opReg;
  logic [2:0]       idx;
  logic [4:0]       pos;
  logic [RES_W-1:0] acc;
  logic             errAcc;

  logic             curBit;
  logic [2:0]       curChunk;
  logic [3:0]       curWeight;
  logic [RES_W-1:0] partial;
  logic [4:0]       nextPos;
  logic             lastChunk;
  logic             badN;

  // Select the current chunk; a 2-bit chunk ignores whatever sits in its MSB slot.
  always_comb begin
    curBit    = 1'b0;
    curChunk  = 3'd0;
    curWeight = 4'd0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (idx == i[2:0]) begin
        curBit    = bitReg[i];
        curChunk  = bitReg[i] ? outReg[3*i +: 3] : {1'b0, outReg[3*i +: 2]};
        curWeight = weightReg[4*i +: 4];
      end
    end
    partial   = RES_W'(curChunk) * RES_W'(opReg);
    nextPos   = pos + (curBit ? 5'd3 : 5'd2);
    lastChunk = (nextPos >= {1'b0, nReg}) || (idx == 3'(CHUNKS - 1));
    badN      = (n < 4'd5) || (n > 4'd12);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      nReg      <= '0;
      bitReg    <= '0;
      outReg    <= '0;
      weightReg <= '0;
      opReg     <= '0;
      idx       <= '0;
      pos       <= '0;
      acc       <= '0;
      errAcc    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            nReg      <= n;
            bitReg    <= divisionBit;
            outReg    <= divisionOut;
            weightReg <= divisionWeight;
            opReg     <= operand;
            idx       <= '0;
            pos       <= '0;
            acc       <= '0;
            errAcc    <= badN;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= badN ? DONE : ACC;
          end
        end
        ACC: begin
          acc <= acc + (partial << curWeight);
          pos <= nextPos;
          idx <= idx + 3'd1;
`ifdef CHUNK_CHECK_EN
          if ({1'b0, curWeight} != pos) errAcc <= 1'b1;
`endif
          if (lastChunk) state <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; afterwards wait for the handshake.
          if (!out_valid) begin
            out_valid <= 1'b1;
            result    <= acc;
            err       <= errAcc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_shift_accumulator.sv
// Directed bench for chunk_shift_accumulator with hand-computed products and latencies.
module tb_chunk_shift_accumulator;
  localparam int OP_W  = 8;
  localparam int RES_W = 12 + OP_W;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, out_valid, out_ready, err, busy;
  logic [3:0]       n;
  logic [5:0]       divisionBit;
  logic [17:0]      divisionOut;
  logic [23:0]      divisionWeight;
  logic [OP_W-1:0]  operand;
  logic [RES_W-1:0] result;

  int nChecks = 0;
  int nFails  = 0;
  int cyc;

  chunk_shift_accumulator #(.OP_W(OP_W), .CHUNKS(6), .RES_W(RES_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .divisionBit(divisionBit), .divisionOut(divisionOut),
    .divisionWeight(divisionWeight), .operand(operand),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic setBundle(input logic [3:0] nv, input logic [5:0] b, input logic [17:0] o,
                           input logic [23:0] w, input logic [OP_W-1:0] op);
    n = nv; divisionBit = b; divisionOut = o; divisionWeight = w; operand = op;
  endtask

  // Present a bundle for exactly one accept edge.
  task automatic startJob(input logic [3:0] nv, input logic [5:0] b, input logic [17:0] o,
                          input logic [23:0] w, input logic [OP_W-1:0] op);
    setBundle(nv, b, o, w, op);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid appears; an expired budget is reported as a failure.
  task automatic waitDone(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) check("timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic consume(input string tag);
    @(posedge clk); #1;
    check({tag, "_ovAfter"}, 32'(out_valid), 32'd0);
    check({tag, "_rdyAfter"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    setBundle(4'd0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_inReady", 32'(in_ready), 32'd1);
    check("rst_outValid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 0xABC as six 2-bit chunks 0,3,3,2,2,2; 0xABC*0x5A = 247320
    startJob(4'd12, 6'b000000, 18'h124D8, 24'hA86420, 8'h5A);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_inReady", 32'(in_ready), 32'd0);
    waitDone(cyc);
    check("t1_latency", 32'(cyc), 32'd7);
    check("t1_result", 32'(result), 32'h3C618);
    check("t1_err", 32'(err), 32'd0);
    consume("t1");

    // 3-bit chunk 5 at weight 0, 2-bit chunk 3 at weight 3: 29*200
    startJob(4'd5, 6'b000001, 18'h0001D, 24'h000030, 8'd200);
    waitDone(cyc);
    check("t2_latency", 32'(cyc), 32'd3);
    check("t2_result", 32'(result), 32'd5800);
    check("t2_err", 32'(err), 32'd0);
    consume("t2");

    // Illegal widths on both sides of the legal range
    startJob(4'd3, 6'b000000, 18'h3FFFF, 24'hFFFFFF, 8'hFF);
    waitDone(cyc);
    check("t3_latency", 32'(cyc), 32'd1);
    check("t3_result", 32'(result), 32'd0);
    check("t3_err", 32'(err), 32'd1);
    consume("t3");
    startJob(4'd13, 6'b000000, 18'h3FFFF, 24'hFFFFFF, 8'hFF);
    waitDone(cyc);
    check("t3b_latency", 32'(cyc), 32'd1);
    check("t3b_err", 32'(err), 32'd1);
    check("t3b_result", 32'(result), 32'd0);
    consume("t3b");

    // Back-pressure: result held, second bundle (57*10) waits for the handshake
    out_ready = 1'b0;
    startJob(4'd5, 6'b000001, 18'h0001D, 24'h000030, 8'd200);
    waitDone(cyc);
    setBundle(4'd6, 6'b000000, 18'h000D1, 24'h000420, 8'd10);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_ovHeld", 32'(out_valid), 32'd1);
      check("t4_resHeld", 32'(result), 32'd5800);
      check("t4_inReady", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_ovDrop", 32'(out_valid), 32'd0);
    check("t4_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t4_accept2", 32'(busy), 32'd1);
    waitDone(cyc);
    check("t4_latency2", 32'(cyc), 32'd4);
    check("t4_result2", 32'(result), 32'd570);
    consume("t4");

    // Reset sampled on the second ACC edge aborts the job
    startJob(4'd12, 6'b000000, 18'h124D8, 24'hA86420, 8'h5A);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_outValid", 32'(out_valid), 32'd0);
    check("t5_inReady", 32'(in_ready), 32'd1);
    startJob(4'd5, 6'b000001, 18'h0001D, 24'h000030, 8'd200);
    waitDone(cyc);
    check("t5_latency", 32'(cyc), 32'd3);
    check("t5_result", 32'(result), 32'd5800);
    consume("t5");

    // Chunks 1,2,3,1 at weights 0,2,5,6: (1+8+96+64)*3; weight 5 disagrees with pos 4
    startJob(4'd8, 6'b000000, 18'h002D1, 24'h006520, 8'd3);
    waitDone(cyc);
    check("t6_latency", 32'(cyc), 32'd5);
    check("t6_result", 32'(result), 32'd507);
`ifdef CHUNK_CHECK_EN
    check("t6_err", 32'(err), 32'd1);
`else
    check("t6_err", 32'(err), 32'd0);
`endif
    consume("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", nChecks);
    $fatal(1, "watchdog");
  end
endmodule
